// File: rtl/ramverify32.sv
// Post-load RAM verifier: re-reads ROM and RAM after boot load, compares each
// word, accumulates a RAM checksum and error stats, and gates the CPU reset.
module ramverify32 #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned N_WORDS = 4096,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic              clk_load,
    input  logic              reset,
    input  logic              load_done,
    output logic [ADDR_W-1:0] addr_rom,
    input  logic [31:0]       data_out_rom,
    output logic [31:0]       addr_ram,
    input  logic [31:0]       data_out_ram,
    output logic              verify_busy,
    output logic              verify_done,
    output logic              verify_ok,
    output logic [15:0]       err_count,
    output logic [31:0]       first_err_addr,
    output logic [31:0]       checksum,
    output logic              cpu_reset
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    // One extra counter bit so N_WORDS = 2**ADDR_W terminates without wrapping.
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(N_WORDS - 1);
    localparam logic [ADDR_W:0] ONE_WORD  = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   word_q, word_d;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [ADDR_W-1:0] pipe_tag_q [RD_LAT];
    logic [ADDR_W-1:0] pipe_tag_d [RD_LAT];
    logic [15:0]       err_q, err_d;
    logic [31:0]       first_q, first_d;
    logic [31:0]       sum_q, sum_d;

    function automatic logic [31:0] byte_addr(input logic [ADDR_W-1:0] w);
        logic [31:0] t;
        t = 32'(w);
        return {t[29:0], 2'b00};
    endfunction

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        err_d   = err_q;
        first_d = first_q;
        sum_d   = sum_q;

        // Token pipe shifts every cycle; stage 0 is loaded only in ISSUE.
        pipe_vld_d    = '0;
        pipe_tag_d[0] = word_q[ADDR_W-1:0];
        for (int unsigned k = 1; k < RD_LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_tag_d[k] = pipe_tag_q[k-1];
        end

        if (pipe_vld_q[RD_LAT-1]) begin
            if (data_out_rom != data_out_ram) begin
                if (err_q != '1) begin
                    err_d = err_q + 16'd1;
                end
                if (err_q == '0) begin
                    first_d = byte_addr(pipe_tag_q[RD_LAT-1]);
                end
            end
            sum_d = sum_q + data_out_ram;
        end

        case (state_q)
            S_IDLE: begin
                if (load_done) begin
                    err_d      = '0;
                    first_d    = '0;
                    sum_d      = '0;
                    word_d     = '0;
                    pipe_vld_d = '0;
                    state_d    = S_ISSUE;
                end
            end
            default: begin
                if (!load_done) begin
                    err_d      = '0;
                    first_d    = '0;
                    sum_d      = '0;
                    word_d     = '0;
                    pipe_vld_d = '0;
                    state_d    = S_IDLE;
                end else if (state_q == S_ISSUE) begin
                    pipe_vld_d[0] = 1'b1;
                    if (word_q == LAST_WORD) begin
                        state_d = S_DRAIN;
                    end else begin
                        word_d = word_q + ONE_WORD;
                    end
                end else if (state_q == S_DRAIN) begin
                    if (pipe_vld_q == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_load or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            pipe_vld_q <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                pipe_tag_q[k] <= '0;
            end
            err_q      <= '0;
            first_q    <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            pipe_vld_q <= pipe_vld_d;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                pipe_tag_q[k] <= pipe_tag_d[k];
            end
            err_q      <= err_d;
            first_q    <= first_d;
            sum_q      <= sum_d;
        end
    end

    always_comb begin
        addr_rom       = word_q[ADDR_W-1:0];
        addr_ram       = byte_addr(word_q[ADDR_W-1:0]);
        verify_busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        verify_done    = (state_q == S_DONE);
        verify_ok      = (state_q == S_DONE) && (err_q == '0);
        cpu_reset      = !verify_ok;
        err_count      = err_q;
        first_err_addr = first_q;
        checksum       = sum_q;
    end

endmodule

// File: tb/tb_ramverify32.sv
// Directed bench for ramverify32: two instances (RD_LAT 1 and 3) over a
// 16-word ROM/RAM model, table-driven full passes plus abort/reset sequences.
module tb_ramverify32;

    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, ld1, ld3, sel3;
    logic [31:0] rom_mem [N];
    logic [31:0] ram_mem [N];

    logic [3:0]  a1_rom;
    logic [31:0] a1_ram, d1_rom, d1_ram, first1, sum1;
    logic        busy1, done1, ok1, cpu1;
    logic [15:0] err1;

    logic [13:0] a3_rom;
    logic [31:0] a3_ram, first3, sum3;
    logic        busy3, done3, ok3, cpu3;
    logic [15:0] err3;
    logic [31:0] s3_rom [3];
    logic [31:0] s3_ram [3];

    ramverify32 #(.ADDR_W(4), .N_WORDS(16), .RD_LAT(1)) dut1 (
        .clk_load(clk), .reset(reset), .load_done(ld1),
        .addr_rom(a1_rom), .data_out_rom(d1_rom),
        .addr_ram(a1_ram), .data_out_ram(d1_ram),
        .verify_busy(busy1), .verify_done(done1), .verify_ok(ok1),
        .err_count(err1), .first_err_addr(first1), .checksum(sum1),
        .cpu_reset(cpu1)
    );

    ramverify32 #(.ADDR_W(14), .N_WORDS(16), .RD_LAT(3)) dut3 (
        .clk_load(clk), .reset(reset), .load_done(ld3),
        .addr_rom(a3_rom), .data_out_rom(s3_rom[2]),
        .addr_ram(a3_ram), .data_out_ram(s3_ram[2]),
        .verify_busy(busy3), .verify_done(done3), .verify_ok(ok3),
        .err_count(err3), .first_err_addr(first3), .checksum(sum3),
        .cpu_reset(cpu3)
    );

    // Synchronous memory models with 1- and 3-cycle read latency
    always @(posedge clk) begin
        d1_rom    <= rom_mem[a1_rom];
        d1_ram    <= ram_mem[a1_ram[5:2]];
        s3_rom[0] <= rom_mem[a3_rom[3:0]];
        s3_ram[0] <= ram_mem[a3_ram[5:2]];
        s3_rom[1] <= s3_rom[0];
        s3_ram[1] <= s3_ram[0];
        s3_rom[2] <= s3_rom[1];
        s3_ram[2] <= s3_ram[1];
    end

    logic        m_busy, m_done, m_ok, m_cpu;
    logic [15:0] m_err;
    logic [31:0] m_first, m_sum;
    assign m_busy  = sel3 ? busy3  : busy1;
    assign m_done  = sel3 ? done3  : done1;
    assign m_ok    = sel3 ? ok3    : ok1;
    assign m_cpu   = sel3 ? cpu3   : cpu1;
    assign m_err   = sel3 ? err3   : err1;
    assign m_first = sel3 ? first3 : first1;
    assign m_sum   = sel3 ? sum3   : sum1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic load_mem(input int mode);
        for (int i = 0; i < N; i++) begin
            rom_mem[i] = 32'(i * 3);
            ram_mem[i] = 32'(i * 3);
            if (mode == 2) begin
                rom_mem[i] = 32'h0;
                ram_mem[i] = 32'hFFFF_FFFF;
            end
        end
        if (mode == 1) begin
            ram_mem[5] = 32'hDEAD_BEEF;
            ram_mem[9] = 32'h1234_5678;
        end
    endtask

    typedef struct {
        int          lat;
        int          mode;
        int          done_edge;
        logic        ok;
        logic [15:0] err;
        logic [31:0] first;
        logic [31:0] sum;
    } vec_t;

    // Full pass: load_done rises, E0 is the next edge; count edges to verify_done.
    task automatic run_pass(input vec_t v);
        int  edge_n;
        logic prev_busy, prev_cpu;
        edge_n = 0;
        prev_busy = 1'b0;
        prev_cpu = 1'b0;
        sel3 = (v.lat == 3);
        @(negedge clk);
        if (sel3) ld3 = 1'b1; else ld1 = 1'b1;
        @(posedge clk); #1;
        chk("busy_at_e0", 32'(m_busy), 32'd1);
        chk("cpu_reset_at_e0", 32'(m_cpu), 32'd1);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (m_done) begin
                edge_n = e;
                break;
            end
            prev_busy = m_busy;
            prev_cpu = m_cpu;
        end
        chk("done_edge", 32'(edge_n), 32'(v.done_edge));
        chk("busy_before_done", 32'(prev_busy), 32'd1);
        chk("cpu_reset_before_done", 32'(prev_cpu), 32'd1);
        chk("busy_at_done", 32'(m_busy), 32'd0);
        chk("verify_ok", 32'(m_ok), 32'(v.ok));
        chk("err_count", 32'(m_err), 32'(v.err));
        chk("first_err_addr", m_first, v.first);
        chk("checksum", m_sum, v.sum);
        chk("cpu_reset_at_done", 32'(m_cpu), 32'(!v.ok));
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", 32'(m_done), 32'd1);
        chk("cpu_reset_held", 32'(m_cpu), 32'(!v.ok));
        @(negedge clk);
        ld1 = 1'b0;
        ld3 = 1'b0;
        @(posedge clk); #1;
        chk("done_after_drop", 32'(m_done), 32'd0);
        chk("err_after_drop", 32'(m_err), 32'd0);
        chk("cpu_reset_after_drop", 32'(m_cpu), 32'd1);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1, 0, 18, 1'b1, 16'd0,  32'h0,  32'd360};
        vecs[1] = '{1, 1, 18, 1'b0, 16'd2,  32'h14, 32'hF0E2_16A5};
        vecs[2] = '{3, 0, 20, 1'b1, 16'd0,  32'h0,  32'd360};
        vecs[3] = '{3, 1, 20, 1'b0, 16'd2,  32'h14, 32'hF0E2_16A5};
        vecs[4] = '{1, 2, 18, 1'b0, 16'd16, 32'h0,  32'hFFFF_FFF0};
        vecs[5] = '{3, 2, 20, 1'b0, 16'd16, 32'h0,  32'hFFFF_FFF0};

        reset = 1'b1;
        ld1 = 1'b0;
        ld3 = 1'b0;
        sel3 = 1'b0;
        load_mem(0);
        #12;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_ok", 32'(ok1), 32'd0);
        chk("rst_cpu_reset", 32'(cpu1), 32'd1);
        chk("rst_addr_ram", a1_ram, 32'd0);
        chk("rst_checksum3", sum3, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            load_mem(vecs[i].mode);
            run_pass(vecs[i]);
        end

        // Abort at E8 after load_done drops following E7, then clean restart
        load_mem(0);
        sel3 = 1'b0;
        @(negedge clk);
        ld1 = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        chk("abort_sum_e7", sum1, 32'd45);
        chk("abort_addr_rom_e7", 32'(a1_rom), 32'd7);
        chk("abort_addr_ram_e7", a1_ram, 32'd28);
        chk("abort_busy_e7", 32'(busy1), 32'd1);
        @(negedge clk);
        ld1 = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_e8", 32'(busy1), 32'd0);
        chk("abort_sum_e8", sum1, 32'd0);
        chk("abort_addr_e8", 32'(a1_rom), 32'd0);
        chk("abort_cpu_reset_e8", 32'(cpu1), 32'd1);
        run_pass(vecs[0]);

        // Asynchronous reset mid-ISSUE with errors already accumulated
        load_mem(2);
        sel3 = 1'b0;
        @(negedge clk);
        ld1 = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        chk("pre_reset_err", 32'(err1), 32'd6);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy1), 32'd0);
        chk("async_rst_err", 32'(err1), 32'd0);
        chk("async_rst_sum", sum1, 32'd0);
        chk("async_rst_first", first1, 32'd0);
        chk("async_rst_addr_rom", 32'(a1_rom), 32'd0);
        chk("async_rst_addr_ram", a1_ram, 32'd0);
        chk("async_rst_cpu_reset", 32'(cpu1), 32'd1);
        @(negedge clk);
        ld1 = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", 32'(busy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ramverify32.md
# ramverify32

Post-load RAM verifier and CPU boot gate, directly downstream of the ROM→RAM boot loader. It waits for the loader's `load_done` and reads every ROM word back alongside the corresponding RAM word. It compares each pair, accumulates a RAM checksum and mismatch statistics, and releases the processor reset only when the image verified clean. The top level routes ROM and RAM read ports to this block while `load_done` is high.

## Interface
- `ADDR_W`, 14: ROM word-address width.
- `N_WORDS`, 4096: number of words verified, word addresses 0..N_WORDS-1.
- `RD_LAT`, 1: read latency of both memories in cycles, address edge to data sampled; legal range 1..4.

- `clk_load` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `load_done` in 1: loader finished; level-sensitive.
- `addr_rom` out ADDR_W: ROM word address.
- `data_out_rom` in 32: ROM read data.
- `addr_ram` out 32: RAM byte address, always word-aligned: {word_addr, 2'b00}, upper bits 0.
- `data_out_ram` in 32: RAM read data.
- `verify_busy` out 1: high in ISSUE/DRAIN.
- `verify_done` out 1: results valid.
- `verify_ok` out 1: high with `verify_done` when err_count = 0.
- `err_count` out 16: mismatching words, saturates at 16'hFFFF.
- `first_err_addr` out 32: RAM byte address of first mismatch; 0 if none.
- `checksum` out 32: sum mod 2^32 of all RAM words read.
- `cpu_reset` out 1: active-high processor reset hold.

## Operation
- Reset values: addresses 0, `verify_busy`/`verify_done`/`verify_ok` 0, `err_count` 0, `first_err_addr` 0, `checksum` 0, `cpu_reset` 1, state IDLE.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on edge with `load_done`=1, clear results and issue counter, set `addr_rom`=0, `addr_ram`=0, go ISSUE.
- ISSUE: each edge, advance the word address by 1 and push a valid token into an RD_LAT-deep shift register. The token is tagged with the word address. After address N_WORDS-1 has been presented, go DRAIN; the address then holds at N_WORDS-1.
- Compare, whenever the tap token is valid: if `data_out_rom` != `data_out_ram`, increment `err_count` (saturating). If this is the first mismatch, latch the tagged byte address into `first_err_addr`. Always add `data_out_ram` into `checksum` (32-bit wraparound).
- DRAIN: wait until the shift register is empty, then go DONE.
- DONE: set `verify_done`=1, `verify_ok`=(err_count==0), and `cpu_reset`=!verify_ok. Hold until abort or reset. A failed verify keeps `cpu_reset`=1 permanently.
- Abort: `load_done` falling in ISSUE/DRAIN/DONE → IDLE next edge, clear all results and the token pipe, `cpu_reset`=1. A subsequent rise restarts verification from word 0.
- `reset` mid-operation: immediate return to reset values; no partial results retained.
- The word counter is ADDR_W+1 bits wide so N_WORDS = 2^ADDR_W terminates without wrap.

## Timing
- E0 = first edge sampling `load_done`=1 in IDLE.
- Word i is presented from E(i) through E(i+1). It is compared at edge E(i+RD_LAT+1).
- The last compare is at E(N_WORDS+RD_LAT). `verify_done`, `verify_ok`, and the `cpu_reset` release all change at E(N_WORDS+RD_LAT+1).
- `verify_busy` is high from E0 until E(N_WORDS+RD_LAT+1).
- One word is verified per cycle; there are no stalls.
- `load_done` is only sampled on clock edges; a glitch between edges has no effect.

## Test plan
- N_WORDS=16, RD_LAT=1, identical memories with word i = i*3, `load_done` rises → `verify_done` at E18, `verify_ok`=1, err_count=0, checksum=360, `cpu_reset` falls at E18.
- Same setup with RAM word 5 corrupted to 32'hDEADBEEF and word 9 corrupted → err_count=2, first_err_addr=0x14, verify_ok=0, `cpu_reset` stays 1.
- RD_LAT=3 with the memory model delayed 3 cycles → results identical to the first test, `verify_done` at E20.
- RAM all 32'hFFFFFFFF, ROM all 0 → checksum=32'hFFFFFFF0, err_count=16.
- `load_done` dropped at E7, then re-raised with clean memories → results cleared at E8, fresh full pass, final verify_ok=1.
- `reset` asserted asynchronously mid-ISSUE → outputs return to reset values immediately, before the next edge; `cpu_reset`=1.
